// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the sequence detector bench:
// state encoding, the default idle line level and the parity helper.
package serial_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SHIFT  = ST_SHIFT,
        S_PARITY = ST_PARITY
    } ser_state_e;

    // Line level while nothing is being shifted; the detector bench relies on it too.
    localparam logic SER_IDLE_BIT = 1'b0;

    function automatic logic even_parity(input logic [31:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of the serializer. The slave modport is the
// serializer's view; the master modport is the word producer / bit consumer.
interface bit_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              o_bit;
    logic              o_bit_valid;
    logic              o_busy;

    modport slave (
        input  i_data,
        input  i_valid,
        output o_ready,
        output o_bit,
        output o_bit_valid,
        output o_busy
    );

    modport master (
        output i_data,
        output i_valid,
        input  o_ready,
        input  o_bit,
        input  o_bit_valid,
        input  o_busy
    );
endinterface

// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with zero-gap streaming of back-to-back words.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_BIT = SER_IDLE_BIT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    bit_serializer_if.slave  bus
);

    localparam int              CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bit_q, bit_d;
    logic              bit_valid_q, bit_valid_d;
`ifdef SER_PARITY_EN
    logic              par_q, par_d;
`endif
    logic              ready_state;
    logic              ready;
    logic              accept;

    // Ready is a function of state and counter only, so i_valid never loops back into it.
    always_comb begin
        ready_state = 1'b0;
        case (state_q)
            S_IDLE:   ready_state = 1'b1;
`ifdef SER_PARITY_EN
            S_PARITY: ready_state = 1'b1;
`else
            S_SHIFT:  ready_state = (cnt_q == LAST_CNT);
`endif
            default:  ready_state = 1'b0;
        endcase
    end

    assign ready  = ready_state & i_rst_n;
    assign accept = bus.i_valid & ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef SER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
            end
            S_SHIFT: begin
                sreg_d = sreg_q << 1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
`ifdef SER_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_IDLE;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            S_PARITY: state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase

        // Accept is only possible where a fresh load is correct, so it overrides the above.
        if (accept) begin
            state_d = S_SHIFT;
            sreg_d  = bus.i_data;
            cnt_d   = '0;
`ifdef SER_PARITY_EN
            par_d   = even_parity(32'(bus.i_data));
`endif
        end
    end

    always_comb begin
        bit_d       = IDLE_BIT;
        bit_valid_d = 1'b0;
        case (state_q)
            S_SHIFT: begin
                bit_d       = sreg_q[DATA_W-1];
                bit_valid_d = 1'b1;
            end
`ifdef SER_PARITY_EN
            S_PARITY: begin
                bit_d       = par_q;
                bit_valid_d = 1'b1;
            end
`endif
            default: begin
                bit_d       = IDLE_BIT;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef SER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bit_q       <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_bit       = bit_q;
    assign bus.o_bit_valid = bit_valid_q;
    assign bus.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: reset, table vectors, back-to-back
// streaming, idle, mid-word reset and a randomized stream against a queue model.
module tb_bit_serializer;
    import serial_pkg::*;

    localparam int DW = 8;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int WC = DW + PB;

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] bits;
        logic          par;
    } vec_t;

    typedef struct packed {
        logic ready;
        logic valid;
        logic b;
    } trace_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bit_serializer_if #(.DATA_W(DW)) bus ();

    bit_serializer #(.DATA_W(DW), .IDLE_BIT(SER_IDLE_BIT)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int     checks = 0;
    int     failures = 0;
    logic   got_q[$];
    logic   exp_q[$];
    trace_t trace_q[$];
    bit     trace_en = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.o_bit_valid) begin
                got_q.push_back(bus.o_bit);
            end else begin
                checks++;
                if (bus.o_bit !== SER_IDLE_BIT) begin
                    failures++;
                    $display("FAIL idle_level o_bit=%b required=%b t=%0t", bus.o_bit, SER_IDLE_BIT, $time);
                end
            end
            if (trace_en) trace_q.push_back('{bus.o_ready, bus.o_bit_valid, bus.o_bit});
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a word and return one step after the edge that accepted it.
    task automatic send(input logic [DW-1:0] w);
        int n;
        n = 0;
        bus.i_data  = w;
        bus.i_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.o_ready) break;
            n++;
            if (n > 60) break;
        end
        checks++;
        if (n > 60) begin
            failures++;
            $display("FAIL send_timeout word=%h never accepted", w);
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_data  = DW'($urandom);
        $display("sent word=%h wait_cycles=%0d", w, n);
    endtask

    // Reference: MSB-first bits of the word, then the count-of-ones parity when enabled.
    task automatic push_model(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(((w >> i) & 1) != 0);
        if (PB == 1) exp_q.push_back(($countones(w) % 2) == 1);
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d required=%0d", name, got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s_bit%0d got=%b required=%b", name, i, got_q[i], exp_q[i]);
                    break;
                end
            end
        end
        $display("stream %s bits=%0d", name, got_q.size());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        vec_t          vt[11];
        logic [DW-1:0] lit;
        int            n;

        bus.i_valid = 1'b0;
        bus.i_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_ready", bus.o_ready, 1'b0);
        check1("rst_bit_valid", bus.o_bit_valid, 1'b0);
        check1("rst_busy", bus.o_busy, 1'b0);
        check1("rst_bit", bus.o_bit, SER_IDLE_BIT);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check1("ready_after_rst", bus.o_ready, 1'b1);
        cycles(1);

        // Table vectors: single words with idle around them
        vt[0]  = '{8'hA5, 8'b1010_0101, 1'b0};
        vt[1]  = '{8'h0F, 8'b0000_1111, 1'b0};
        vt[2]  = '{8'hF0, 8'b1111_0000, 1'b0};
        vt[3]  = '{8'h80, 8'b1000_0000, 1'b1};
        vt[4]  = '{8'h01, 8'b0000_0001, 1'b1};
        vt[5]  = '{8'hFF, 8'b1111_1111, 1'b0};
        vt[6]  = '{8'h00, 8'b0000_0000, 1'b0};
        vt[7]  = '{8'h07, 8'b0000_0111, 1'b1};
        vt[8]  = '{8'h03, 8'b0000_0011, 1'b0};
        vt[9]  = '{8'h4D, 8'b0100_1101, 1'b0};
        vt[10] = '{8'hB6, 8'b1011_0110, 1'b1};
        for (int k = 0; k < 11; k++) begin
            got_q.delete();
            exp_q.delete();
            send(vt[k].data);
            cycles(WC + 3);
            lit = vt[k].bits;
            for (int i = DW - 1; i >= 0; i--) exp_q.push_back(lit[i]);
            if (PB == 1) exp_q.push_back(vt[k].par);
            compare_stream($sformatf("vec%0d", k));
            check1($sformatf("vec%0d_busy_after", k), bus.o_busy, 1'b0);
            check1($sformatf("vec%0d_ready_after", k), bus.o_ready, 1'b1);
        end

        // Back-to-back 0F, F0 with valid held across the boundary
        got_q.delete();
        exp_q.delete();
        trace_q.delete();
        trace_en = 1'b1;
        send(8'h0F);
        send(8'hF0);
        cycles(2 * WC + 3);
        trace_en = 1'b0;
        push_model(8'h0F);
        push_model(8'hF0);
        compare_stream("b2b");
        if (trace_q.size() < 2 * WC + 2) begin
            checks++;
            failures++;
            $display("FAIL b2b_trace_len got=%0d required>=%0d", trace_q.size(), 2 * WC + 2);
        end else begin
            for (int k = 0; k < 2 * WC; k++)
                check1($sformatf("b2b_ready_c%0d", k), trace_q[k].ready, (k == 0) || (k == WC));
            for (int k = 0; k < 2 * WC + 2; k++)
                check1($sformatf("b2b_valid_c%0d", k), trace_q[k].valid, (k >= 2) && (k < 2 + 2 * WC));
        end

        // Idle for 10 cycles
        for (int k = 0; k < 10; k++) begin
            bus.i_data = DW'($urandom);
            @(negedge clk);
            check1("idle_valid", bus.o_bit_valid, 1'b0);
            check1("idle_busy", bus.o_busy, 1'b0);
            check1("idle_ready", bus.o_ready, 1'b1);
            @(posedge clk);
            #1;
        end
        $display("idle 10 cycles done");

        // Reset after three bits of FF, then a clean 80
        got_q.delete();
        send(8'hFF);
        n = 0;
        while (got_q.size() < 3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check1("rst_mid_reached_3bits", got_q.size() >= 3, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check1("rst_mid_ready_forced", bus.o_ready, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check1("rst_mid_valid", bus.o_bit_valid, 1'b0);
        check1("rst_mid_busy", bus.o_busy, 1'b0);
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        send(8'h80);
        cycles(WC + 3);
        lit = 8'b1000_0000;
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(lit[i]);
        if (PB == 1) exp_q.push_back(1'b1);
        compare_stream("after_rst_80");

        // Randomized stream with random gaps, including zero-gap runs
        got_q.delete();
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic [DW-1:0] w;
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                bus.i_data = DW'($urandom);
                cycles(1);
            end
            w = DW'($urandom);
            send(w);
            push_model(w);
        end
        cycles(2 * WC + 4);
        compare_stream("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
